// File: rtl/async_fifo_rd_ctrl_if.sv
// ---------------------------------------------------------------------------
// async_fifo_rd_ctrl_if
// Purpose : bundles the read-side signals of the async FIFO read controller.
// Signals :
//   wptr_gray [AWIDTH:0]   Gray write pointer from the write domain (async)
//   mem_rdata [DWIDTH-1:0] combinational storage read data at raddr
//   rready                 consumer accepts rdata this cycle
//   rptr_gray [AWIDTH:0]   registered Gray read pointer to the write domain
//   raddr     [AWIDTH-1:0] storage read address
//   rdata     [DWIDTH-1:0] registered output word
//   rvalid                 rdata holds a valid word
//   rempty                 !rvalid
//   rlevel    [AWIDTH+1:0] words available to the consumer (0..DEPTH+1)
// Handshake: a word moves from rdata to the consumer on every rising clk edge
// where rvalid && rready. While rvalid && !rready, rdata/rvalid are held
// stable. rvalid never depends combinationally on rready.
// Modports: slave = controller side, master = consumer/write-side/storage.
// ---------------------------------------------------------------------------
interface async_fifo_rd_ctrl_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4
);
  logic [AWIDTH:0]   wptr_gray;
  logic [DWIDTH-1:0] mem_rdata;
  logic              rready;
  logic [AWIDTH:0]   rptr_gray;
  logic [AWIDTH-1:0] raddr;
  logic [DWIDTH-1:0] rdata;
  logic              rvalid;
  logic              rempty;
  logic [AWIDTH+1:0] rlevel;

  modport slave (
    input  wptr_gray, mem_rdata, rready,
    output rptr_gray, raddr, rdata, rvalid, rempty, rlevel
  );

  modport master (
    output wptr_gray, mem_rdata, rready,
    input  rptr_gray, raddr, rdata, rvalid, rempty, rlevel
  );
endinterface

// File: rtl/async_fifo_rd_ctrl.sv
// ---------------------------------------------------------------------------
// async_fifo_rd_ctrl
// Purpose : read-domain controller of an asynchronous FIFO. Synchronizes the
//           Gray write pointer, detects storage empty, and fetches words from
//           external storage into a one-word registered output stage.
// Ports   :
//   clk   read-domain clock, rising edge
//   rstb  asynchronous active-low reset (release synchronous to clk)
//   bus   async_fifo_rd_ctrl_if.slave (see interface header for signals)
// ---------------------------------------------------------------------------
module async_fifo_rd_ctrl #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 4,
  parameter int SYNC_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rstb,
  async_fifo_rd_ctrl_if.slave   bus
);

  function automatic logic [AWIDTH:0] bin2gray(input logic [AWIDTH:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AWIDTH:0] gray2bin(input logic [AWIDTH:0] g);
    logic [AWIDTH:0] b;
    b[AWIDTH] = g[AWIDTH];
    for (int i = AWIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Write-pointer synchronizer chain; stage 0 is the metastability catcher.
  logic [AWIDTH:0] sync_q [SYNC_DEPTH];
  logic [AWIDTH:0] wq_gray;
  logic [AWIDTH:0] wq_bin;

  logic [AWIDTH:0]   rbin_q, rbin_d;
  logic [AWIDTH:0]   rptr_gray_q, rptr_gray_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;

  logic mem_empty;
  logic fetch;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < SYNC_DEPTH; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= bus.wptr_gray;
      for (int i = 1; i < SYNC_DEPTH; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wq_gray = sync_q[SYNC_DEPTH-1];
  assign wq_bin  = gray2bin(wq_gray);

  // Empty compares Gray codes directly: both are registered, so no decode
  // glitch can reach the compare.
  assign mem_empty = (rptr_gray_q == wq_gray);
  assign fetch     = !mem_empty && (!rvalid_q || bus.rready);

  always_comb begin
    rbin_d   = rbin_q;
    rdata_d  = rdata_q;
    rvalid_d = rvalid_q;
    if (fetch) begin
      rbin_d   = rbin_q + 1'b1;
      rdata_d  = bus.mem_rdata;
      rvalid_d = 1'b1;
    end else if (rvalid_q && bus.rready) begin
      // Consumed with nothing to refill: storage must be empty here.
      rvalid_d = 1'b0;
    end
    // Gray pointer is computed from the next binary value and registered
    // alongside it, so the write domain only ever sees a clean flop output.
    rptr_gray_d = bin2gray(rbin_d);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rbin_q      <= '0;
      rptr_gray_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      rbin_q      <= rbin_d;
      rptr_gray_q <= rptr_gray_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign bus.rptr_gray = rptr_gray_q;
  assign bus.raddr     = rbin_q[AWIDTH-1:0];
  assign bus.rdata     = rdata_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rempty    = !rvalid_q;
  // Words still in storage (as seen through the synchronizer) plus the held one.
  assign bus.rlevel    = {1'b0, wq_bin - rbin_q} + {{(AWIDTH+1){1'b0}}, rvalid_q};

endmodule
